tone_gen: RTL and testbench

//   Square-wave tone generator fed by the integer divider that converts clock

---
 rtl/tone_gen_pkg.sv | 22 ++
 rtl/tone_gen.sv | 104 ++++++++++
 tb/tb_tone_gen.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/tone_gen_pkg.sv
// Shared definitions for the tone path: generator state encoding, the default
// minimum audible period and the duty-to-high-length helper.
package tone_gen_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StHigh = 2'd1,
      StLow  = 2'd2
   } tone_state_e;

   // Below 16 clk cycles the 1/16 duty setting would round high_len to zero.
   localparam int unsigned DefaultMinPeriod = 16;

   // High half-period for a given full period and volume (duty 1/2 .. 1/16).
   function automatic logic [31:0] high_len_of(input logic [31:0] period,
                                               input logic [1:0]  vol);
      logic [2:0] shamt;
      shamt = {1'b0, vol} + 3'd1;
      return period >> shamt;
   endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave tone generator: turns a period count into a duty-scaled waveform,
// re-latching period/volume only at wave-period boundaries so halves never tear.
module tone_gen
   import tone_gen_pkg::*;
#(
   parameter int unsigned MIN_PERIOD = DefaultMinPeriod
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [31:0] period,
   input  logic [1:0]  vol,
   output logic        wave,
   output logic        cycle_tick,
   output logic        active
);

   tone_state_e state_q;
   logic [31:0] cnt_q;
   logic [31:0] low_len_q;

   logic        start_ok;
   logic [31:0] high_len_new;
   logic [31:0] low_len_new;

   always_comb begin
      start_ok     = en && (period >= MIN_PERIOD);
      high_len_new = high_len_of(period, vol);
      low_len_new  = period - high_len_new;
   end

   // The high length is consumed immediately by the counter load, so only the
   // low length needs to be held across the wave period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         low_len_q  <= '0;
         wave       <= 1'b0;
         cycle_tick <= 1'b0;
         active     <= 1'b0;
      end else begin
         cycle_tick <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start_ok) begin
                  state_q    <= StHigh;
                  cnt_q      <= high_len_new - 32'd1;
                  low_len_q  <= low_len_new;
                  wave       <= 1'b1;
                  cycle_tick <= 1'b1;
                  active     <= 1'b1;
               end else begin
                  wave   <= 1'b0;
                  active <= 1'b0;
               end
            end
            StHigh: begin
               if (!en) begin
                  state_q <= StIdle;
                  cnt_q   <= '0;
                  wave    <= 1'b0;
                  active  <= 1'b0;
               end else if (cnt_q != 32'd0) begin
                  cnt_q <= cnt_q - 32'd1;
               end else begin
                  state_q <= StLow;
                  cnt_q   <= low_len_q - 32'd1;
                  wave    <= 1'b0;
               end
            end
            StLow: begin
               if (!en) begin
                  state_q <= StIdle;
                  cnt_q   <= '0;
                  wave    <= 1'b0;
                  active  <= 1'b0;
               end else if (cnt_q != 32'd0) begin
                  cnt_q <= cnt_q - 32'd1;
               end else if (start_ok) begin
                  // Boundary with no gap cycle: next period starts right here.
                  state_q    <= StHigh;
                  cnt_q      <= high_len_new - 32'd1;
                  low_len_q  <= low_len_new;
                  wave       <= 1'b1;
                  cycle_tick <= 1'b1;
               end else begin
                  state_q <= StIdle;
                  cnt_q   <= '0;
                  wave    <= 1'b0;
                  active  <= 1'b0;
               end
            end
            default: begin
               state_q <= StIdle;
               cnt_q   <= '0;
               wave    <= 1'b0;
               active  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tone_gen.sv
// Directed bench for tone_gen: waveform shape, boundary re-latch, mute, low
// period handling and asynchronous reset.
module tb_tone_gen;

   logic        clk;
   logic        rst;
   logic        en;
   logic [31:0] period;
   logic [1:0]  vol;
   logic        wave;
   logic        cycle_tick;
   logic        active;

   int n_checks;
   int n_fails;

   tone_gen #(.MIN_PERIOD(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .period     (period),
      .vol        (vol),
      .wave       (wave),
      .cycle_tick (cycle_tick),
      .active     (active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one clock; sample point is 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, " wave"}, {31'd0, wave}, 32'd0);
      check_eq({tag, " tick"}, {31'd0, cycle_tick}, 32'd0);
      check_eq({tag, " active"}, {31'd0, active}, 32'd0);
   endtask

   // Check n cycles of a running wave, phase k0 onward, against high/total.
   task automatic run_pattern(input string tag, input int high, input int total,
                              input int n, input int k0);
      for (int k = k0; k < k0 + n; k++) begin
         check_eq({tag, " wave"}, {31'd0, wave}, ((k % total) < high) ? 32'd1 : 32'd0);
         check_eq({tag, " tick"}, {31'd0, cycle_tick}, ((k % total) == 0) ? 32'd1 : 32'd0);
         check_eq({tag, " active"}, {31'd0, active}, 32'd1);
         step();
      end
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      rst      = 1'b1;
      en       = 1'b0;
      period   = 32'd0;
      vol      = 2'd0;
      step();
      step();
      check_idle("in_reset");
      rst = 1'b0;
      step();
      check_idle("after_reset");

      // 1: 50% duty, first high one clk after en
      period = 32'd20;
      vol    = 2'd0;
      en     = 1'b1;
      step();
      run_pattern("t1_p20_v0", 10, 20, 40, 0);

      en = 1'b0;
      step();
      check_idle("t1_mute");

      // 2: 1/8 duty
      vol = 2'd2;
      en  = 1'b1;
      step();
      run_pattern("t2_p20_v2", 2, 20, 40, 0);
      en = 1'b0;
      step();
      check_idle("t2_mute");

      // 3: period change mid-HIGH waits for the boundary
      vol = 2'd0;
      en  = 1'b1;
      step();
      run_pattern("t3_pre", 10, 20, 3, 0);
      period = 32'd40;
      run_pattern("t3_finish20", 10, 20, 17, 3);
      run_pattern("t3_p40", 20, 40, 40, 0);

      // 4: en dropped on the third HIGH cycle
      run_pattern("t4_pre", 20, 40, 2, 0);
      en = 1'b0;
      step();
      check_idle("t4_muted");
      for (int i = 0; i < 5; i++) begin
         step();
         check_idle("t4_stay");
      end

      // 5: periods below the minimum never start
      period = 32'd15;
      en     = 1'b1;
      for (int i = 0; i < 25; i++) begin
         step();
         check_idle("t5_p15");
      end
      period = 32'd0;
      for (int i = 0; i < 10; i++) begin
         step();
         check_idle("t5_p0");
      end
      period = 32'd16;
      step();
      run_pattern("t5_p16", 8, 16, 32, 0);

      // 6: async reset mid-LOW clears outputs before the next edge
      run_pattern("t6_pre", 8, 16, 10, 0);
      #2;
      rst = 1'b1;
      #1;
      check_idle("t6_async");
      en = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      step();
      check_idle("t6_released");
      period = 32'd20;
      vol    = 2'd1;
      en     = 1'b1;
      step();
      run_pattern("t6_restart", 5, 20, 20, 0);

      // Low period mid-wave ignored until the boundary, then idle
      period = 32'd8;
      run_pattern("t7_low_mid", 5, 20, 20, 0);
      check_idle("t7_boundary_idle");
      step();
      check_idle("t7_stay");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
